// File: rtl/alu_mc.sv
// ============================================================================
// Module  : alu_mc
// Brief   : Multi-cycle EX-stage ALU with valid/ready handshakes, iterative
//           unsigned multiply (shift-add) and divide (restoring).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LUI   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_hi;
  logic               r_ovf;
  logic               r_dbz;
  logic               r_has_res;

  // Iterative working set: {r_wh, r_wl} is the running product or the
  // remainder/quotient pair, r_a the multiplicand or divisor.
  logic [WIDTH-1:0]   r_wh;
  logic [WIDTH-1:0]   r_wl;
  logic [WIDTH-1:0]   r_a;
  logic               r_op_mul;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_div0;
  logic               w_long;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dsh;
  logic               w_dge;
  logic [WIDTH-1:0]   w_dsub;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_div0    = (ALUOp == OP_DIVU) && (data2 == '0);
  assign w_long    = (ALUOp == OP_MULTU) || ((ALUOp == OP_DIVU) && (data2 != '0));
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_sum  = data1 + data2;
  assign w_diff = data1 - data2;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUOp)
      OP_AND:  w_res = data1 & data2;
      OP_OR:   w_res = data1 | data2;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_LUI:  w_res = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      default: w_res = '0;
    endcase
  end

  // One multiply or divide step per BUSY cycle.
  always_comb begin
    w_msum  = {1'b0, r_wh} + {1'b0, (r_wl[0] ? r_a : {WIDTH{1'b0}})};
    w_dsh   = {r_wh, r_wl[WIDTH-1]};
    w_dge   = (w_dsh >= {1'b0, r_a});
    w_dsub  = w_dsh[WIDTH-1:0] - r_a;
    w_it_hi = '0;
    w_it_lo = '0;
    if (r_op_mul) begin
      w_it_hi = w_msum[WIDTH:1];
      w_it_lo = {w_msum[0], r_wl[WIDTH-1:1]};
    end else begin
      w_it_hi = w_dge ? w_dsub : w_dsh[WIDTH-1:0];
      w_it_lo = {r_wl[WIDTH-2:0], w_dge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_long ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res     <= '0;
      r_hi      <= '0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
      r_has_res <= 1'b0;
      r_wh      <= '0;
      r_wl      <= '0;
      r_a       <= '0;
      r_op_mul  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_long) begin
              r_op_mul <= (ALUOp == OP_MULTU);
              r_wh     <= '0;
              r_wl     <= (ALUOp == OP_MULTU) ? data2 : data1;
              r_a      <= (ALUOp == OP_MULTU) ? data1 : data2;
              r_cnt    <= '0;
            end else if (w_div0) begin
              r_res     <= '1;
              r_hi      <= data1;
              r_ovf     <= 1'b0;
              r_dbz     <= 1'b1;
              r_has_res <= 1'b1;
            end else begin
              r_res     <= w_res;
              r_hi      <= '0;
              r_ovf     <= w_ovf;
              r_dbz     <= 1'b0;
              r_has_res <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_wh  <= w_it_hi;
          r_wl  <= w_it_lo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_res     <= w_it_lo;
            r_hi      <= w_it_hi;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
            r_has_res <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ALUResult = r_res;
  assign ALUHi     = r_hi;
  assign Overflow  = r_ovf;
  assign DivByZero = r_dbz;
  assign Zero      = r_has_res && (r_res == '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module  : tb_alu_mc
// Brief   : Self-checking directed bench for alu_mc (WIDTH = 32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUHi;
  logic             Zero;
  logic             Overflow;
  logic             DivByZero;

  int n_chk = 0;
  int n_err = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .ALUHi     (ALUHi),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .DivByZero (DivByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             ovf;
    logic             dbz;
    int               lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_result(output int lat, output bit done);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) done = 1'b1;
      else chk("busy in_ready", {63'd0, in_ready}, 64'd0);
    end
    if (!done) chk("timeout out_valid", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    chk("in_ready before accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    ALUOp    = op;
    data1    = a;
    data2    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data1    = $urandom;
    data2    = $urandom;
    ALUOp    = 4'b0010;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit done;
    issue(v.op, v.a, v.b);
    wait_result(lat, done);
    if (done) begin
      chk({tag, " latency"},   64'(lat), 64'(v.lat));
      chk({tag, " ALUResult"}, 64'(ALUResult), 64'(v.res));
      chk({tag, " ALUHi"},     64'(ALUHi), 64'(v.hi));
      chk({tag, " Zero"},      {63'd0, Zero}, {63'd0, v.z});
      chk({tag, " Overflow"},  {63'd0, Overflow}, {63'd0, v.ovf});
      chk({tag, " DivByZero"}, {63'd0, DivByZero}, {63'd0, v.dbz});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, " idle after handoff"}, {62'd0, out_valid, in_ready}, 64'd1);
    end
  endtask

  initial begin
    int  lat;
    bit  done;
    vec_t v;

    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'b0011, 32'hDEADBEEF, 32'h00001234, 32'h12340000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
    vecs[9]  = '{4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33};
    vecs[10] = '{4'b1001, 32'h00000055, 32'h00000000, 32'hFFFFFFFF, 32'h55, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{4'b0100, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[12] = '{4'b1000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b1, 1'b0, 1'b0, 33};
    vecs[13] = '{4'b1000, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 33};
    vecs[14] = '{4'b1001, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 1'b0, 33};
    vecs[15] = '{4'b1001, 32'd5, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0, 1'b0, 33};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data1     = '0;
    data2     = '0;
    ALUOp     = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready",  {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset ALUResult", 64'(ALUResult), 64'd0);
    chk("reset ALUHi",     64'(ALUHi), 64'd0);
    chk("reset flags",     {61'd0, Zero, Overflow, DivByZero}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and a new request must be ignored.
    issue(4'b0010, 32'd2, 32'd3);
    wait_result(lat, done);
    if (done) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        ALUOp    = 4'b0010;
        data1    = 32'd100;
        data2    = 32'd200;
        @(negedge clk);
        chk("bp out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp in_ready",  {63'd0, in_ready}, 64'd0);
        chk("bp ALUResult", 64'(ALUResult), 64'd5);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp idle after release", {62'd0, out_valid, in_ready}, 64'd1);
      @(negedge clk);
      chk("bp no stray accept", {62'd0, out_valid, in_ready}, 64'd1);
    end

    // Reset asserted during the 10th BUSY cycle of a multiply.
    issue(4'b1000, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("mid-busy out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort in_ready",  {63'd0, in_ready}, 64'd1);
    chk("abort ALUResult", 64'(ALUResult), 64'd0);
    chk("abort ALUHi",     64'(ALUHi), 64'd0);
    chk("abort flags",     {61'd0, Zero, Overflow, DivByZero}, 64'd0);
    reset = 1'b0;

    v = '{4'b0010, 32'd3, 32'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1};
    run_vec(v, "post-abort add");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
